// File: rtl/pps_monitor.sv
// Pulse-per-second monitor: measures input period, reports lock and loss of signal.
// Optional `PPS_ERRCOUNT_EN adds a saturating o_err_count of bad periods and timeouts.
module pps_monitor #(
    parameter int unsigned CLOCK_RATE_HZ = 100_000_000,
    parameter int unsigned TOLERANCE     = 1000,
    parameter int unsigned LOCK_COUNT    = 3
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_pps,
    output logic        o_valid,
    output logic [31:0] o_period,
    output logic        o_locked,
    output logic        o_timeout
`ifdef PPS_ERRCOUNT_EN
    ,
    output logic [15:0] o_err_count
`endif
);

    localparam int unsigned CNT_W  = 32;
    localparam int unsigned GOOD_W = 4;
    localparam int unsigned CMP_W  = 34;

    // Limits are widened and signed so a tolerance larger than the rate cannot wrap.
    localparam logic signed [CMP_W-1:0] PERIOD_MIN =
        $signed(CMP_W'(CLOCK_RATE_HZ)) - $signed(CMP_W'(TOLERANCE));
    localparam logic signed [CMP_W-1:0] PERIOD_MAX =
        $signed(CMP_W'(CLOCK_RATE_HZ)) + $signed(CMP_W'(TOLERANCE));
    localparam logic [CNT_W-1:0] TIMEOUT_CNT =
        CNT_W'(64'(CLOCK_RATE_HZ) + 64'(CLOCK_RATE_HZ) - 64'd1);
    localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state, state_d;
    logic                sync1, sync2, prev;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [GOOD_W-1:0]   good, good_d, good_inc;
    logic                valid_d, locked_d, timeout_d;
    logic [CNT_W-1:0]    period_d, period_meas;
    logic signed [CMP_W-1:0] period_s;
    logic                pps_edge, period_good, timeout_hit;

    assign pps_edge    = sync2 & ~prev;
    assign period_meas = cnt + CNT_W'(1);
    assign period_s    = $signed(CMP_W'(period_meas));
    assign period_good = (period_s >= PERIOD_MIN) && (period_s <= PERIOD_MAX);
    assign timeout_hit = (state != IDLE) && !pps_edge && (cnt == TIMEOUT_CNT);
    assign good_inc    = (good < LOCK_TGT) ? good + GOOD_W'(1) : good;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        good_d    = good;
        valid_d   = 1'b0;
        period_d  = o_period;
        locked_d  = o_locked;
        timeout_d = o_timeout;

        if (pps_edge) begin
            cnt_d = '0;
            case (state)
                IDLE: begin
                    state_d   = ARMED;
                    timeout_d = 1'b0;
                end
                ARMED: begin
                    valid_d  = 1'b1;
                    period_d = period_meas;
                    if (period_good) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_TGT) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    valid_d  = 1'b1;
                    period_d = period_meas;
                    if (!period_good) begin
                        state_d  = ARMED;
                        locked_d = 1'b0;
                        good_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            good_d    = '0;
        end else if (state != IDLE) begin
            cnt_d = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            prev      <= 1'b0;
            state     <= IDLE;
            cnt       <= '0;
            good      <= '0;
            o_valid   <= 1'b0;
            o_period  <= '0;
            o_locked  <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            sync1     <= i_pps;
            sync2     <= sync1;
            prev      <= sync2;
            state     <= state_d;
            cnt       <= cnt_d;
            good      <= good_d;
            o_valid   <= valid_d;
            o_period  <= period_d;
            o_locked  <= locked_d;
            o_timeout <= timeout_d;
        end
    end

`ifdef PPS_ERRCOUNT_EN
    logic err_inc;

    // Every out-of-tolerance strobe and every loss-of-signal event is an error.
    assign err_inc = (pps_edge && (state != IDLE) && !period_good) || timeout_hit;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_err_count <= '0;
        end else if (err_inc && (o_err_count != 16'hFFFF)) begin
            o_err_count <= o_err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pps_monitor.sv
// Scoreboard bench for pps_monitor at CLOCK_RATE_HZ=1000, TOLERANCE=5, LOCK_COUNT=3.
module tb_pps_monitor;

    localparam int unsigned CLK_HZ   = 1000;
    localparam int unsigned TOL      = 5;
    localparam int unsigned LOCKN    = 3;
    localparam int unsigned LATENCY  = 3;
    localparam int unsigned HIGH_CYC = 400;
    localparam int unsigned NSTEP    = 18;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        pps   = 1'b0;
    logic        valid;
    logic [31:0] period;
    logic        locked;
    logic        timeout;
`ifdef PPS_ERRCOUNT_EN
    logic [15:0] err_count;
`endif

    pps_monitor #(
        .CLOCK_RATE_HZ(CLK_HZ),
        .TOLERANCE    (TOL),
        .LOCK_COUNT   (LOCKN)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .i_pps    (pps),
        .o_valid  (valid),
        .o_period (period),
        .o_locked (locked),
        .o_timeout(timeout)
`ifdef PPS_ERRCOUNT_EN
        ,
        .o_err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned rise_cyc;
        logic [31:0] period;
        logic        locked;
    } exp_t;

    typedef struct {
        int unsigned gap;
        bit          v;
        int unsigned p;
        bit          l;
        int unsigned err;
    } step_t;

    exp_t        exp_q[$];
    exp_t        e;
    bit          due;
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned last_rise = 0;
    step_t       seq[NSTEP];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, want, cyc);
        end
    endtask

    // Strobe monitor: a strobe is due exactly LATENCY cycles after its input rise.
    always @(negedge clk) begin
        if (rst_n) begin
            due = (exp_q.size() != 0) && (exp_q[0].rise_cyc + LATENCY == cyc);
            if (valid || due) begin
                chk("valid_strobe", 32'(valid), 32'(due));
                if (due) begin
                    e = exp_q.pop_front();
                    if (valid) begin
                        chk("period", period, e.period);
                        chk("locked_at_strobe", 32'(locked), 32'(e.locked));
                    end
                end
            end
        end
    end

    task automatic rise(input bit exp_v, input int unsigned p, input bit l);
        pps       = 1'b1;
        last_rise = cyc;
        if (exp_v) exp_q.push_back('{cyc, p, l});
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            if (i + 1 == HIGH_CYC) pps = 1'b0;
        end
    endtask

    task automatic reset_phase(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            pps = ~pps;
            chk("reset_flags", 32'({valid, locked, timeout}), 32'd0);
            chk("reset_period", period, 32'd0);
        end
        pps = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_until(input int unsigned target);
        int unsigned guard = 0;
        while (cyc < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    initial begin
        seq = '{
            '{1000, 1'b0,    0, 1'b0, 0},
            '{1000, 1'b1, 1000, 1'b0, 0},
            '{1000, 1'b1, 1000, 1'b0, 0},
            '{1006, 1'b1, 1000, 1'b1, 0},
            '{1000, 1'b1, 1006, 1'b0, 1},
            '{1000, 1'b1, 1000, 1'b0, 1},
            '{1000, 1'b1, 1000, 1'b0, 1},
            '{ 994, 1'b1, 1000, 1'b1, 1},
            '{ 995, 1'b1,  994, 1'b0, 2},
            '{1005, 1'b1,  995, 1'b0, 2},
            '{ 995, 1'b1, 1005, 1'b0, 2},
            '{1006, 1'b1,  995, 1'b1, 2},
            '{ 995, 1'b1, 1006, 1'b0, 3},
            '{ 994, 1'b1,  995, 1'b0, 3},
            '{1005, 1'b1,  994, 1'b0, 4},
            '{1000, 1'b1, 1005, 1'b0, 4},
            '{1000, 1'b1, 1000, 1'b0, 4},
            '{   0, 1'b1, 1000, 1'b1, 4}
        };

        // Reset with toggling input, then release with input low.
        reset_phase(12);
        run(20);

        // Locking, a bad period, relock, tolerance boundaries.
        for (int i = 0; i < NSTEP - 1; i++) begin
            rise(seq[i].v, seq[i].p, seq[i].l);
            run(seq[i].gap);
            chk("locked_level", 32'(locked), 32'(seq[i].l));
`ifdef PPS_ERRCOUNT_EN
            chk("err_count", 32'(err_count), seq[i].err);
`endif
        end

        // Final lock, then the input stops.
        rise(seq[NSTEP-1].v, seq[NSTEP-1].p, seq[NSTEP-1].l);
        run(HIGH_CYC + 10);
        wait_until(last_rise + LATENCY + 2 * CLK_HZ - 1);
        chk("timeout_early", 32'(timeout), 32'd0);
        chk("locked_before_timeout", 32'(locked), 32'd1);
        @(negedge clk);
        chk("timeout_set", 32'(timeout), 32'd1);
        chk("locked_after_timeout", 32'(locked), 32'd0);
        chk("period_held", period, 32'd1000);
`ifdef PPS_ERRCOUNT_EN
        chk("err_count_timeout", 32'(err_count), 32'd5);
`endif
        run(300);
        chk("timeout_holds", 32'(timeout), 32'd1);

        // Recovery: first edge only clears timeout, then strobes resume.
        rise(1'b0, 0, 1'b0);
        run(LATENCY - 1);
        chk("timeout_before_clear", 32'(timeout), 32'd1);
        run(1);
        chk("timeout_cleared", 32'(timeout), 32'd0);
        run(1000 - LATENCY);
        rise(1'b1, 1000, 1'b0);
        run(1000);
        rise(1'b1, 1000, 1'b0);
        run(1000);
        rise(1'b1, 1000, 1'b1);
        run(LATENCY);
        chk("relocked_strobe", 32'({valid, locked}), 32'd3);

        // Asynchronous reset between clock edges during the lock strobe.
        #1 rst_n = 1'b0;
        #1;
        chk("async_flags", 32'({valid, locked, timeout}), 32'd0);
        chk("async_period", period, 32'd0);
`ifdef PPS_ERRCOUNT_EN
        chk("async_err_count", 32'(err_count), 32'd0);
`endif
        reset_phase(6);
        run(20);
        rise(1'b0, 0, 1'b0);
        run(1000);
        rise(1'b1, 1000, 1'b0);
        run(20);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
